// File: rtl/pe2ddr_wr_ctrl_pkg.sv
// Shared constants and types for the PE-to-DDR write path.
// Other DDR read/write controllers reuse the beat geometry and state encoding.
package pe2ddr_wr_ctrl_pkg;

  localparam int DDR_W         = 512;
  localparam int DDR_BYTES     = DDR_W / 8;
  localparam int DDR_BURST_LEN = 16;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    ADDR,
    DATA,
    RESP
  } wr_state_t;

endpackage

// File: rtl/pe2ddr_wr_ctrl_fifo.sv
// Synchronous show-ahead FIFO: head is valid in the same cycle as !empty.
// Push when full and pop when empty are ignored.
module fifo_sync_fwft #(
  parameter int DW    = 512,
  parameter int DEPTH = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [DW-1:0]                push_data,
  input  logic                         pop,
  output logic [DW-1:0]                head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0]    mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: storage is deliberately not reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pe2ddr_wr_ctrl.sv
// Buffers a DDR-beat stream and writes it out as fixed-length AXI bursts,
// one burst outstanding at a time, from a linear address counter.
module pe2ddr_wr_ctrl #(
  parameter int DDR_W      = pe2ddr_wr_ctrl_pkg::DDR_W,
  parameter int AXI_ADDR_W = 32,
  parameter int BURST_LEN  = pe2ddr_wr_ctrl_pkg::DDR_BURST_LEN,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  done,
  input  logic [AXI_ADDR_W-1:0] conf_base_addr,
  input  logic [15:0]           conf_beat_num,
  input  logic [DDR_W-1:0]      s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [AXI_ADDR_W-1:0] m_awaddr,
  output logic [7:0]            m_awlen,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [DDR_W-1:0]      m_wdata,
  output logic                  m_wlast,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  input  logic                  m_bvalid,
  output logic                  m_bready
);

  import pe2ddr_wr_ctrl_pkg::*;

  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int BB_W       = $clog2(BURST_LEN + 1);
  localparam int BEAT_BYTES = DDR_W / 8;

  wr_state_t             state;
  logic [AXI_ADDR_W-1:0] addr;
  logic [15:0]           rem_cnt;
  logic [7:0]            beat_cnt;
  logic [BB_W-1:0]       burst_beats;
  logic                  push;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;

  always_comb begin
    burst_beats = BB_W'(BURST_LEN);
    if (rem_cnt < 16'(BURST_LEN)) burst_beats = BB_W'(rem_cnt);
  end

  // The FIFO absorbs the stream in every active state so upstream only
  // stalls on a full buffer; W is gated to DATA so it never precedes AW.
  assign s_ready  = (state != IDLE) && !fifo_full;
  assign push     = s_valid && s_ready;
  assign m_wvalid = (state == DATA) && !fifo_empty;
  assign pop      = m_wvalid && m_wready;
  assign m_wlast  = m_wvalid && (beat_cnt == m_awlen);
  assign m_bready = (state == RESP);

  fifo_sync_fwft #(
    .DW    (DDR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (s_data),
    .pop       (pop),
    .head      (m_wdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      done      <= 1'b1;
      addr      <= '0;
      rem_cnt   <= '0;
      beat_cnt  <= '0;
      m_awaddr  <= '0;
      m_awlen   <= '0;
      m_awvalid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && conf_beat_num != '0) begin
            addr    <= conf_base_addr;
            rem_cnt <= conf_beat_num;
            done    <= 1'b0;
            state   <= FILL;
          end
        end
        FILL: begin
          // Wait for the whole burst to be buffered so W never starves mid-burst.
          if (fifo_count >= CNT_W'(burst_beats)) begin
            m_awaddr  <= addr;
            m_awlen   <= 8'(burst_beats - 1'b1);
            m_awvalid <= 1'b1;
            state     <= ADDR;
          end
        end
        ADDR: begin
          if (m_awready) begin
            m_awvalid <= 1'b0;
            addr      <= addr + AXI_ADDR_W'(burst_beats) * AXI_ADDR_W'(BEAT_BYTES);
            beat_cnt  <= '0;
            state     <= DATA;
          end
        end
        DATA: begin
          if (pop) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (beat_cnt == m_awlen) begin
              rem_cnt <= rem_cnt - 16'(burst_beats);
              state   <= RESP;
            end
          end
        end
        RESP: begin
          if (m_bvalid) begin
            if (rem_cnt == '0) begin
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              state <= FILL;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe2ddr_wr_ctrl.sv
// Directed bench for pe2ddr_wr_ctrl: stream source, AXI write slave and
// expected-burst model are stepped one cycle at a time from one initial block.
module tb_pe2ddr_wr_ctrl;

  localparam int DDR_W      = 512;
  localparam int AXI_ADDR_W = 32;
  localparam int BURST_LEN  = 16;
  localparam int FIFO_DEPTH = 64;
  localparam int BEAT_BYTES = DDR_W / 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic                  done;
  logic [AXI_ADDR_W-1:0] conf_base_addr;
  logic [15:0]           conf_beat_num;
  logic [DDR_W-1:0]      s_data;
  logic                  s_valid;
  logic                  s_ready;
  logic [AXI_ADDR_W-1:0] m_awaddr;
  logic [7:0]            m_awlen;
  logic                  m_awvalid;
  logic                  m_awready;
  logic [DDR_W-1:0]      m_wdata;
  logic                  m_wlast;
  logic                  m_wvalid;
  logic                  m_wready;
  logic                  m_bvalid;
  logic                  m_bready;

  always #5 clk = ~clk;

  pe2ddr_wr_ctrl #(
    .DDR_W      (DDR_W),
    .AXI_ADDR_W (AXI_ADDR_W),
    .BURST_LEN  (BURST_LEN),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .done           (done),
    .conf_base_addr (conf_base_addr),
    .conf_beat_num  (conf_beat_num),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .m_awaddr       (m_awaddr),
    .m_awlen        (m_awlen),
    .m_awvalid      (m_awvalid),
    .m_awready      (m_awready),
    .m_wdata        (m_wdata),
    .m_wlast        (m_wlast),
    .m_wvalid       (m_wvalid),
    .m_wready       (m_wready),
    .m_bvalid       (m_bvalid),
    .m_bready       (m_bready)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  logic [31:0] exp_base;
  int exp_n, exp_bursts, sent, aw_count, w_count, b_count;
  int w_in_burst, cur_len, b_wait, bdelay, first_aw_cyc, push_last_cyc;
  bit aw_busy, w_open, b_pending, done_chk, src_en, wready_en;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DDR_W-1:0] make_beat(input int idx);
    logic [DDR_W-1:0] b;
    for (int i = 0; i < DDR_W / 32; i++) b[i*32 +: 32] = 32'(idx * 16 + i) ^ 32'h5A5A_0000;
    return b;
  endfunction

  task automatic begin_test(input logic [31:0] base, input int n);
    conf_base_addr = base;
    conf_beat_num  = 16'(n);
    exp_base       = base;
    exp_n          = n;
    exp_bursts     = (n + BURST_LEN - 1) / BURST_LEN;
    sent = 0; aw_count = 0; w_count = 0; b_count = 0; w_in_burst = 0; cur_len = 0;
    b_wait = 0; first_aw_cyc = -1; push_last_cyc = -1;
    aw_busy = 0; w_open = 0; b_pending = 0; done_chk = 0;
  endtask

  // One clock cycle: drive inputs after negedge, observe handshakes, advance.
  task automatic tick();
    int rem;
    s_valid   = !rst && src_en && (sent < exp_n);
    s_data    = make_beat(sent);
    m_awready = !rst;
    m_wready  = !rst && wready_en;
    m_bvalid  = !rst && b_pending && (b_wait == 0);
    #1;
    if (!rst) begin
      if (done_chk) begin
        check("done_after_b", done, 1'b1);
        done_chk = 0;
      end
      if (m_awvalid && first_aw_cyc < 0) first_aw_cyc = cyc;
      if (s_valid && s_ready) begin
        if (sent == BURST_LEN - 1) push_last_cyc = cyc;
        sent++;
      end
      if (m_bvalid && m_bready) begin
        b_pending = 0;
        aw_busy   = 0;
        b_count++;
        if (b_count == exp_bursts) done_chk = 1;
      end else if (b_pending && b_wait > 0) begin
        b_wait--;
      end
      if (m_awvalid && m_awready) begin
        rem = exp_n - aw_count * BURST_LEN;
        cur_len = ((rem < BURST_LEN) ? rem : BURST_LEN) - 1;
        check("aw_while_busy", aw_busy, 1'b0);
        check("awaddr", m_awaddr, exp_base + 32'(aw_count * BURST_LEN * BEAT_BYTES));
        check("awlen", m_awlen, cur_len);
        aw_busy = 1; w_open = 1; w_in_burst = 0;
        aw_count++;
      end
      if (m_wvalid && m_wready) begin
        check("w_before_aw", w_open, 1'b1);
        check("wdata", m_wdata, make_beat(w_count));
        check("wlast", m_wlast, w_in_burst == cur_len);
        w_count++;
        w_in_burst++;
        if (w_in_burst == cur_len + 1) begin
          w_open = 0; b_pending = 1; b_wait = bdelay;
        end
      end
    end
    @(negedge clk);
    cyc++;
    start = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    check("done_after_start", done, exp_n == 0);
  endtask

  task automatic run_to_end(input int budget);
    int k = 0;
    while (b_count < exp_bursts && k < budget) begin
      tick();
      k++;
    end
    tick();
    check("aw_count", aw_count, exp_bursts);
    check("w_count", w_count, exp_n);
    check("b_count", b_count, exp_bursts);
    check("beats_pushed", sent, exp_n);
    check("done_idle", done, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; conf_base_addr = '0; conf_beat_num = '0;
    s_valid = 1'b0; s_data = '0; m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0;
    src_en = 1; wready_en = 1; bdelay = 0;
    begin_test(32'h0, 0);
    @(negedge clk);
    repeat (3) tick();

    // Reset state
    check("rst_done", done, 1'b1);
    check("rst_s_ready", s_ready, 1'b0);
    check("rst_awvalid", m_awvalid, 1'b0);
    check("rst_wvalid", m_wvalid, 1'b0);
    check("rst_wlast", m_wlast, 1'b0);
    check("rst_bready", m_bready, 1'b0);
    check("rst_awaddr", m_awaddr, 32'h0);
    check("rst_awlen", m_awlen, 8'h0);
    rst = 1'b0;
    tick();

    // Single full burst, plus AW latency after the 16th push
    begin_test(32'h1000, 16);
    pulse_start();
    run_to_end(200);
    check("aw_latency", first_aw_cyc - push_last_cyc, 2);

    // Three bursts with a partial 8-beat tail
    begin_test(32'h1000, 40);
    pulse_start();
    run_to_end(300);

    // W backpressure for 100 cycles after the first AW fills the FIFO
    begin_test(32'h1000, 80);
    wready_en = 0;
    pulse_start();
    for (int k = 0; k < 100 && aw_count < 1; k++) tick();
    check("bp_first_aw", aw_count, 1);
    repeat (100) tick();
    check("bp_pushed_to_full", sent, FIFO_DEPTH);
    check("bp_s_ready_low", s_ready, 1'b0);
    check("bp_no_w", w_count, 0);
    wready_en = 1;
    run_to_end(400);

    // Slow write responses: no second AW until the first B, stream keeps filling
    begin_test(32'h1000, 32);
    bdelay = 20;
    pulse_start();
    for (int k = 0; k < 200 && b_count < 1; k++) tick();
    check("slow_b_one_resp", b_count, 1);
    check("slow_b_one_aw", aw_count, 1);
    check("slow_b_stream_filled", sent, 32);
    run_to_end(200);
    bdelay = 0;

    // beat_num == 0: no activity, done stays high
    begin_test(32'h1000, 0);
    pulse_start();
    repeat (10) tick();
    check("zero_done", done, 1'b1);
    check("zero_s_ready", s_ready, 1'b0);
    check("zero_aw", aw_count, 0);
    check("zero_w", w_count, 0);

    // start while busy is ignored; the model keeps the first configuration
    begin_test(32'h3000, 32);
    pulse_start();
    repeat (5) tick();
    conf_base_addr = 32'h5000;
    conf_beat_num  = 16'd16;
    start = 1'b1;
    tick();
    check("busy_start_done", done, 1'b0);
    run_to_end(300);

    // Reset after beat 5 of burst 2, then a fresh run at 0x2000
    begin_test(32'h1000, 48);
    pulse_start();
    for (int k = 0; k < 300 && w_count < BURST_LEN + 5; k++) tick();
    check("mid_rst_reached", w_count, BURST_LEN + 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    s_valid = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0;
    #1;
    check("mid_rst_done", done, 1'b1);
    check("mid_rst_awvalid", m_awvalid, 1'b0);
    check("mid_rst_wvalid", m_wvalid, 1'b0);
    check("mid_rst_bready", m_bready, 1'b0);
    check("mid_rst_s_ready", s_ready, 1'b0);
    @(negedge clk);
    begin_test(32'h2000, 20);
    pulse_start();
    run_to_end(300);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
